// File: rtl/pl_symbol_scrambler.sv
// Applies the randomizer's Rn as an Rn*90 degree I/Q rotation to data symbols; headers pass through.
// One registered output stage (1-cycle latency); s_ready = ~m_valid | m_ready, and a stall freezes FSM and randomizer.
module pl_symbol_scrambler #(
  parameter int W        = 8,
  parameter int HDR_LEN  = 64,
  parameter int DATA_LEN = 1024
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] s_q,
  input  logic         s_sof,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_i,
  output logic [W-1:0] m_q,
  output logic         m_sof,
  output logic         m_eof,
  output logic         o_rnd_reset,
  output logic         o_rnd_en,
  input  logic [1:0]   i_rnd,
  output logic         o_drop,
  output logic         o_sync_err
);

  localparam int MAX_LEN = (HDR_LEN > DATA_LEN) ? HDR_LEN : DATA_LEN;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [W-1:0]  MIN_V     = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MAX_V     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  ONE_V     = {{(W-1){1'b0}}, 1'b1};

  if (HDR_LEN < 1)  $error("HDR_LEN must be at least 1");
  if (DATA_LEN < 1) $error("DATA_LEN must be at least 1");

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           m_valid_q;
  logic [W-1:0]   m_i_q;
  logic [W-1:0]   m_q_q;
  logic           m_sof_q;
  logic           m_eof_q;
  logic           drop_q;
  logic           sync_err_q;

  logic           accept;
  logic [W-1:0]   rot_i_d;
  logic [W-1:0]   rot_q_d;

  // Two's-complement negation that clamps the most negative code instead of wrapping.
  function automatic logic [W-1:0] neg_sat(input logic [W-1:0] x);
    if (x == MIN_V) begin
      return MAX_V;
    end
    return (~x) + ONE_V;
  endfunction

  assign s_ready = ~m_valid_q | m_ready;
  assign accept  = s_valid & s_ready;

  // Reseed on every sof so the first data symbol always sees the seed-state Rn.
  assign o_rnd_reset = i_reset | (accept & s_sof);
  assign o_rnd_en    = accept & ~s_sof & (state_q == DATA);

  always_comb begin
    rot_i_d = s_i;
    rot_q_d = s_q;
    case (i_rnd)
      2'd1: begin
        rot_i_d = neg_sat(s_q);
        rot_q_d = s_i;
      end
      2'd2: begin
        rot_i_d = neg_sat(s_i);
        rot_q_d = neg_sat(s_q);
      end
      2'd3: begin
        rot_i_d = s_q;
        rot_q_d = neg_sat(s_i);
      end
      default: begin
        rot_i_d = s_i;
        rot_q_d = s_q;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      m_valid_q  <= 1'b0;
      m_i_q      <= '0;
      m_q_q      <= '0;
      m_sof_q    <= 1'b0;
      m_eof_q    <= 1'b0;
      drop_q     <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      drop_q     <= 1'b0;
      sync_err_q <= 1'b0;
      if (s_ready) begin
        m_valid_q <= 1'b0;
        m_sof_q   <= 1'b0;
        m_eof_q   <= 1'b0;
        if (s_valid) begin
          if (s_sof) begin
            // A sof mid-frame abandons the old frame without an eof.
            sync_err_q <= (state_q != IDLE);
            m_valid_q  <= 1'b1;
            m_i_q      <= s_i;
            m_q_q      <= s_q;
            m_sof_q    <= 1'b1;
            if (HDR_LEN == 1) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end else begin
              state_q <= HEADER;
              cnt_q   <= CNT_ONE;
            end
          end else begin
            case (state_q)
              IDLE: begin
                drop_q <= 1'b1;
              end
              HEADER: begin
                m_valid_q <= 1'b1;
                m_i_q     <= s_i;
                m_q_q     <= s_q;
                if (cnt_q == HDR_LAST) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
                end else begin
                  cnt_q <= cnt_q + CNT_ONE;
                end
              end
              DATA: begin
                m_valid_q <= 1'b1;
                m_i_q     <= rot_i_d;
                m_q_q     <= rot_q_d;
                if (cnt_q == DATA_LAST) begin
                  m_eof_q <= 1'b1;
                  state_q <= IDLE;
                  cnt_q   <= '0;
                end else begin
                  cnt_q <= cnt_q + CNT_ONE;
                end
              end
              default: begin
                state_q <= IDLE;
                cnt_q   <= '0;
              end
            endcase
          end
        end
      end
    end
  end

  assign m_valid    = m_valid_q;
  assign m_i        = m_i_q;
  assign m_q        = m_q_q;
  assign m_sof      = m_sof_q;
  assign m_eof      = m_eof_q;
  assign o_drop     = drop_q;
  assign o_sync_err = sync_err_q;

endmodule

// File: tb/tb_pl_symbol_scrambler.sv
// Bench for pl_symbol_scrambler: frame-position reference model, randomizer stub with a fixed Rn table,
// random data, random valid gaps and random downstream stalls.
module tb_pl_symbol_scrambler;
  localparam int W        = 8;
  localparam int HDR_LEN  = 4;
  localparam int DATA_LEN = 8;
  localparam int FLEN     = HDR_LEN + DATA_LEN;
  localparam int MAXV     = (1 << (W - 1)) - 1;
  localparam int MINV     = -(1 << (W - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                i_reset;
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_i;
  logic signed [W-1:0] s_q;
  logic                s_sof;
  logic                m_valid;
  logic                m_ready;
  logic        [W-1:0] m_i;
  logic        [W-1:0] m_q;
  logic                m_sof;
  logic                m_eof;
  logic                o_rnd_reset;
  logic                o_rnd_en;
  logic        [1:0]   i_rnd;
  logic                o_drop;
  logic                o_sync_err;

  pl_symbol_scrambler #(.W(W), .HDR_LEN(HDR_LEN), .DATA_LEN(DATA_LEN)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready), .m_i(m_i), .m_q(m_q), .m_sof(m_sof), .m_eof(m_eof),
    .o_rnd_reset(o_rnd_reset), .o_rnd_en(o_rnd_en), .i_rnd(i_rnd),
    .o_drop(o_drop), .o_sync_err(o_sync_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Randomizer stub: step k of the sequence since the last reseed.
  logic [1:0] rn_seq [0:255];
  int         rk = 0;
  logic       rnd_force = 1'b0;
  logic [1:0] rnd_fval = 2'd0;
  assign i_rnd = rnd_force ? rnd_fval : rn_seq[rk[7:0]];
  always @(posedge clk) begin
    if (o_rnd_reset) rk <= 0;
    else if (o_rnd_en) rk <= rk + 1;
  end

  function automatic int clampv(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic void rotate(input int i, input int q, input int r, output int oi, output int oq);
    case (r)
      1:       begin oi = -q; oq = i;  end
      2:       begin oi = -i; oq = -q; end
      3:       begin oi = q;  oq = -i; end
      default: begin oi = i;  oq = q;  end
    endcase
    oi = clampv(oi);
    oq = clampv(oq);
  endfunction

  typedef struct {int i; int q; bit sof; bit eof;} exp_t;
  exp_t expq[$];
  bit   in_frame = 1'b0;
  int   idx = 0;
  int   k_model = 0;
  bit   exp_drop = 1'b0;
  bit   exp_sync = 1'b0;
  bit   chk_en = 1'b0;
  bit   held = 1'b0;
  logic [W-1:0] h_i, h_q;
  logic h_sof, h_eof;
  int   en_cnt = 0, drop_cnt = 0, sync_cnt = 0;
  int   obs_i[$], obs_q[$];
  bit   stall_mode = 1'b0;

  always @(negedge clk) begin
    bit acc;
    exp_t e;
    int ri, rq, r;
    if (chk_en) begin
      chk("o_drop", 32'(o_drop), 32'(exp_drop));
      chk("o_sync_err", 32'(o_sync_err), 32'(exp_sync));
      if (o_rnd_en === 1'b1) en_cnt++;
      if (o_drop === 1'b1) drop_cnt++;
      if (o_sync_err === 1'b1) sync_cnt++;
      if (held) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_i", 32'(m_i), 32'(h_i));
        chk("stall_q", 32'(m_q), 32'(h_q));
        chk("stall_sof", 32'(m_sof), 32'(h_sof));
        chk("stall_eof", 32'(m_eof), 32'(h_eof));
      end
      chk("m_valid", 32'(m_valid), 32'(expq.size() != 0));
      chk("s_ready", 32'(s_ready), 32'(!m_valid || m_ready));
      acc = s_valid && s_ready && !i_reset;
      chk("o_rnd_reset", 32'(o_rnd_reset), 32'(i_reset || (acc && s_sof)));
      if (!(acc && s_sof))
        chk("o_rnd_en", 32'(o_rnd_en), 32'(acc && in_frame && idx >= HDR_LEN));
      if (m_valid === 1'b1 && m_ready && expq.size() != 0) begin
        e = expq.pop_front();
        chk("m_i", 32'($signed(m_i)), e.i);
        chk("m_q", 32'($signed(m_q)), e.q);
        chk("m_sof", 32'(m_sof), 32'(e.sof));
        chk("m_eof", 32'(m_eof), 32'(e.eof));
        obs_i.push_back(int'($signed(m_i)));
        obs_q.push_back(int'($signed(m_q)));
      end
      held = (m_valid === 1'b1) && !m_ready && !i_reset;
      h_i = m_i; h_q = m_q; h_sof = m_sof; h_eof = m_eof;
      exp_drop = 1'b0;
      exp_sync = 1'b0;
      if (i_reset) begin
        expq.delete();
        in_frame = 1'b0;
        held = 1'b0;
      end else if (acc) begin
        if (s_sof) begin
          if (in_frame) exp_sync = 1'b1;
          in_frame = 1'b1;
          idx = 0;
          k_model = 0;
        end
        if (!in_frame) begin
          exp_drop = 1'b1;
        end else begin
          if (idx < HDR_LEN) begin
            e.i = int'(s_i); e.q = int'(s_q);
          end else begin
            r = rnd_force ? int'(rnd_fval) : int'(rn_seq[k_model]);
            rotate(int'(s_i), int'(s_q), r, ri, rq);
            e.i = ri; e.q = rq;
            k_model++;
          end
          e.sof = (idx == 0);
          e.eof = (idx == FLEN - 1);
          expq.push_back(e);
          idx++;
          if (idx == FLEN) in_frame = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    m_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic send(input logic signed [W-1:0] vi, input logic signed [W-1:0] vq, input bit sof, input int gap);
    bit got;
    int budget;
    s_valid = 1'b0;
    repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    s_valid = 1'b1; s_i = vi; s_q = vq; s_sof = sof;
    budget = 0;
    do begin
      @(negedge clk); got = s_ready;
      @(posedge clk); #1;
      budget++;
    end while (!got && budget < 200);
    if (!got) timeout_fail("send");
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  // mode 0: all symbols (10,3); mode 1: random; mode 2: header (1,2), data (-128,5)
  task automatic send_frame(input int mode, input int gap, input int stop_after);
    logic signed [W-1:0] vi, vq;
    for (int n = 0; n < FLEN && n != stop_after; n++) begin
      case (mode)
        1:       begin vi = W'($urandom); vq = W'($urandom); end
        2:       begin vi = (n < HDR_LEN) ? 8'sd1 : -8'sd128; vq = (n < HDR_LEN) ? 8'sd2 : 8'sd5; end
        default: begin vi = 8'sd10; vq = 8'sd3; end
      endcase
      send(vi, vq, n == 0, gap);
    end
  endtask

  task automatic drain();
    int b = 0;
    while ((expq.size() != 0 || m_valid !== 1'b0) && b < 500) begin @(posedge clk); #1; b++; end
    if (b >= 500) timeout_fail("drain");
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    obs_i.delete(); obs_q.delete();
  endtask

  int ref_i[$], ref_q[$];

  task automatic cmp_ref(input string name, input int offset);
    chk({name, "_len"}, obs_i.size(), offset + FLEN);
    if (obs_i.size() >= offset + FLEN)
      for (int n = 0; n < FLEN; n++) begin
        chk({name, "_i"}, obs_i[offset + n], ref_i[n]);
        chk({name, "_q"}, obs_q[offset + n], ref_q[n]);
      end
  endtask

  initial begin
    int pi, pq;
    for (int k = 0; k < 256; k++) rn_seq[k] = 2'($urandom_range(0, 3));
    rn_seq[0] = 2'd1; rn_seq[1] = 2'd2; rn_seq[2] = 2'd3; rn_seq[3] = 2'd0;
    i_reset = 1'b1; s_valid = 1'b0; s_i = '0; s_q = '0; s_sof = 1'b0; m_ready = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_i", 32'(m_i), 0);
    chk("rst_m_q", 32'(m_q), 0);
    chk("rst_m_sof", 32'(m_sof), 0);
    chk("rst_m_eof", 32'(m_eof), 0);
    chk("rst_rnd_reset", 32'(o_rnd_reset), 1);
    chk("rst_rnd_en", 32'(o_rnd_en), 0);
    @(posedge clk); #1; i_reset = 1'b0;

    rotate(10, 3, 1, pi, pq);   chk("pin_r1_i", pi, -3);   chk("pin_r1_q", pq, 10);
    rotate(10, 3, 2, pi, pq);   chk("pin_r2_i", pi, -10);  chk("pin_r2_q", pq, -3);
    rotate(10, 3, 3, pi, pq);   chk("pin_r3_i", pi, 3);    chk("pin_r3_q", pq, -10);
    rotate(-128, 5, 2, pi, pq); chk("pin_sat_i", pi, 127); chk("pin_sat_q", pq, -5);

    // Reference frame, no stalls.
    clear_obs(); en_cnt = 0;
    send_frame(0, 0, -1); drain();
    chk("frameA_rnd_en", en_cnt, DATA_LEN);
    chk("frameA_len", obs_i.size(), FLEN);
    if (obs_i.size() >= HDR_LEN + 3) begin
      chk("frameA_hdr_i", obs_i[0], 10);
      chk("frameA_d0_i", obs_i[HDR_LEN], -3);
      chk("frameA_d0_q", obs_q[HDR_LEN], 10);
      chk("frameA_d1_i", obs_i[HDR_LEN + 1], -10);
      chk("frameA_d1_q", obs_q[HDR_LEN + 1], -3);
      chk("frameA_d2_i", obs_i[HDR_LEN + 2], 3);
    end
    ref_i = obs_i; ref_q = obs_q;

    // Symbols outside a frame are dropped.
    drop_cnt = 0;
    for (int n = 0; n < 3; n++) send(8'sd7, 8'sd7, 1'b0, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("drop_count", drop_cnt, 3);

    // Saturating negation with forced Rn=2.
    rnd_force = 1'b1; rnd_fval = 2'd2; clear_obs();
    send_frame(2, 0, -1); drain();
    rnd_force = 1'b0;
    if (obs_i.size() > HDR_LEN) begin
      chk("sat_i", obs_i[HDR_LEN], 127);
      chk("sat_q", obs_q[HDR_LEN], -5);
    end else timeout_fail("sat_obs");

    // Stalls: the same frame must come out identical.
    stall_mode = 1'b1; clear_obs(); en_cnt = 0;
    send_frame(0, 2, -1); drain();
    chk("stall_rnd_en", en_cnt, DATA_LEN);
    cmp_ref("stall_vs_ref", 0);
    for (int f = 0; f < 6; f++) begin
      en_cnt = 0;
      send_frame(1, f % 3, -1); drain();
      chk("rand_rnd_en", en_cnt, DATA_LEN);
    end
    stall_mode = 1'b0;

    // sof at data symbol 5 restarts the frame.
    sync_cnt = 0; clear_obs();
    send_frame(1, 0, HDR_LEN + 4);
    send_frame(0, 0, -1); drain();
    chk("sync_count", sync_cnt, 1);
    cmp_ref("sync_restart", HDR_LEN + 4);

    // Reset mid-DATA, then the next frame scrambles like the first.
    send_frame(1, 0, HDR_LEN + 3);
    i_reset = 1'b1;
    @(negedge clk); chk("midrst_rnd_reset", 32'(o_rnd_reset), 1);
    @(posedge clk); #1; i_reset = 1'b0;
    @(negedge clk); chk("midrst_m_valid", 32'(m_valid), 0);
    @(posedge clk); #1;
    clear_obs();
    send_frame(0, 0, -1); drain();
    cmp_ref("after_reset", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
